// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory-wait timeout and status pulses.
// Optional feature: define MC_JR_EN to decode R-type funct 001000 as jr.
module multicycle_control #(
  parameter int ALUOP_W      = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic [1:0]         branch,
  output logic [1:0]         jump,
  output logic [2:0]         state,
  output logic               retire,
  output logic               bus_err,
  output logic               illegal
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT_MAX);

  logic [2:0] state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic       is_r, is_jr, is_imm, is_lw, is_sw, is_br, is_bne, is_j, is_jal, is_legal;
  logic [3:0] imm_alu;
  logic       wait_lim;

  always_comb begin
    is_r    = 1'b0;
    is_imm  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_br   = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    imm_alu = 4'd1;
    case (op)
      6'b000000: is_r = 1'b1;
      6'b001000,
      6'b001001: is_imm = 1'b1;
      6'b001100: begin is_imm = 1'b1; imm_alu = 4'd2; end
      6'b001101: begin is_imm = 1'b1; imm_alu = 4'd3; end
      6'b001110: begin is_imm = 1'b1; imm_alu = 4'd5; end
      6'b001111: begin is_imm = 1'b1; imm_alu = 4'd7; end
      6'b100011: is_lw = 1'b1;
      6'b101011: is_sw = 1'b1;
      6'b000100: is_br = 1'b1;
      6'b000101: begin is_br = 1'b1; is_bne = 1'b1; end
      6'b000010: is_j = 1'b1;
      6'b000011: is_jal = 1'b1;
      default: ;
    endcase
    is_legal = is_r | is_imm | is_lw | is_sw | is_br | is_j | is_jal;
  end

`ifdef MC_JR_EN
  assign is_jr = is_r && (funct == 6'b001000);
`else
  logic unused_funct;
  assign unused_funct = ^funct;
  assign is_jr        = 1'b0;
`endif

  // Limit reached while still not ready: abort; a same-cycle ready wins.
  assign wait_lim = (wait_cnt_q == WAIT_LIM) && !mem_ready;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = '0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    branch        = 2'b00;
    jump          = 2'b00;
    retire        = 1'b0;
    bus_err       = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALUOP_W'(4'd1);
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_lim) begin
          bus_err = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALUOP_W'(4'd1);
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_jr) begin
          pc_write  = 1'b1;
          pc_source = 2'd3;
          jump      = 2'b11;
          alu_src_a = 1'b1;
          retire    = 1'b1;
        end else if (is_r) begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_W'(4'd8);
          state_d   = S_WB;
        end else if (is_imm || is_lw || is_sw) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = ALUOP_W'(is_imm ? imm_alu : 4'd1);
          state_d   = is_imm ? S_WB : S_MEM;
        end else if (is_br) begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_W'(4'd1);
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
          branch        = is_bne ? 2'b10 : 2'b01;
          retire        = 1'b1;
        end else if (is_j || is_jal) begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
          jump      = is_jal ? 2'b10 : 2'b01;
          reg_write = is_jal;
          retire    = 1'b1;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
          retire  = !is_lw;
        end else if (wait_lim) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle traces built from the instruction-level rules, replayed against the DUT.
module tb_multicycle_control;

  localparam int AW   = 4;
  localparam int MAXW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op, funct;
  logic          mem_ready;
  logic          mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_source, alu_src_b, branch, jump;
  logic          alu_src_a, reg_write, reg_dst, mem_to_reg, retire, bus_err, illegal;
  logic [AW-1:0] alu_op;
  logic [2:0]    state;

  multicycle_control #(.ALUOP_W(AW), .MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .branch(branch), .jump(jump), .state(state), .retire(retire),
    .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       rd, wr, iord, irw, pcw, pcwc;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [3:0] aluop;
    logic       rw, rdst, m2r;
    logic [1:0] br, jp;
    logic       ret, berr, ill;
    logic       rdy;
  } cyc_t;

  localparam logic [5:0] OPS [13] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                      6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

  cyc_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic cyc_t observe();
    cyc_t o;
    o.st = state; o.rd = mem_read; o.wr = mem_write; o.iord = iord;
    o.irw = ir_write; o.pcw = pc_write; o.pcwc = pc_write_cond; o.pcs = pc_source;
    o.asa = alu_src_a; o.asb = alu_src_b; o.aluop = alu_op[3:0];
    o.rw = reg_write; o.rdst = reg_dst; o.m2r = mem_to_reg;
    o.br = branch; o.jp = jump; o.ret = retire; o.berr = bus_err; o.ill = illegal;
    o.rdy = mem_ready;
    return o;
  endfunction

  task automatic check(input string tag, input cyc_t e);
    cyc_t o;
    o = observe();
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: state=%0d got=%h expected=%h", tag, e.st, o, e);
    end
  endtask

  // A memory access that becomes ready after w stalls; w > MAXW never becomes ready.
  task automatic access(input cyc_t base, input int w, output bit ok);
    cyc_t e;
    int   stalls;
    stalls = (w > MAXW) ? MAXW : w;
    for (int i = 0; i < stalls; i++) q.push_back(base);
    e  = base;
    ok = (w <= MAXW);
    if (ok) e.rdy = 1'b1;
    else    e.berr = 1'b1;
    if (ok && base.st == 3'd1) begin e.irw = 1'b1; e.pcw = 1'b1; end
    if (ok && base.wr) e.ret = 1'b1;
    q.push_back(e);
  endtask

  task automatic wb(input logic rdst, input logic m2r);
    cyc_t e;
    e = blank(3'd5); e.rw = 1'b1; e.rdst = rdst; e.m2r = m2r; e.ret = 1'b1;
    q.push_back(e);
  endtask

  task automatic build(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
    cyc_t e;
    bit   ok;
    bit   jr;
`ifdef MC_JR_EN
    jr = (o == 6'h00) && (f == 6'b001000);
`else
    jr = 1'b0;
`endif
    e = blank(3'd1); e.rd = 1'b1; e.asb = 2'd1; e.aluop = 4'd1;
    access(e, fw, ok);
    if (!ok) access(e, 0, ok);
    e = blank(3'd2); e.asb = 2'd3; e.aluop = 4'd1;
    if (!(o inside {OPS})) begin
      e.ill = 1'b1;
      q.push_back(e);
      return;
    end
    q.push_back(e);
    e = blank(3'd3);
    case (o)
      6'h00: if (jr) begin
               e.pcw = 1'b1; e.pcs = 2'd3; e.jp = 2'b11; e.asa = 1'b1; e.ret = 1'b1;
               q.push_back(e);
             end else begin
               e.asa = 1'b1; e.aluop = 4'd8; q.push_back(e); wb(1'b1, 1'b0);
             end
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        e.asa = 1'b1; e.asb = 2'd2;
        e.aluop = (o == 6'h0C) ? 4'd2 : (o == 6'h0D) ? 4'd3 :
                  (o == 6'h0E) ? 4'd5 : (o == 6'h0F) ? 4'd7 : 4'd1;
        q.push_back(e); wb(1'b0, 1'b0);
      end
      6'h23, 6'h2B: begin
        e.asa = 1'b1; e.asb = 2'd2; e.aluop = 4'd1; q.push_back(e);
        e = blank(3'd4); e.iord = 1'b1; e.rd = (o == 6'h23); e.wr = (o == 6'h2B);
        access(e, mw, ok);
        if (ok && o == 6'h23) wb(1'b0, 1'b1);
      end
      6'h04, 6'h05: begin
        e.asa = 1'b1; e.aluop = 4'd1; e.pcwc = 1'b1; e.pcs = 2'd1;
        e.br = (o == 6'h05) ? 2'b10 : 2'b01; e.ret = 1'b1; q.push_back(e);
      end
      default: begin
        e.pcw = 1'b1; e.pcs = 2'd2; e.jp = (o == 6'h03) ? 2'b10 : 2'b01;
        e.rw = (o == 6'h03); e.ret = 1'b1; q.push_back(e);
      end
    endcase
  endtask

  // Replay at most n queued cycles; op/funct are applied from the first cycle onward.
  task automatic play(input string tag, input logic [5:0] o, input logic [5:0] f, input int n);
    cyc_t e;
    int   k;
    k = 0;
    while (q.size() > 0 && k < n) begin
      e = q.pop_front();
      @(negedge clk);
      op = o; funct = f; mem_ready = e.rdy;
      #1;
      check(tag, e);
      k++;
    end
    q.delete();
  endtask

  task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input int fw, input int mw);
    build(o, f, fw, mw);
    play(tag, o, f, 1000);
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return MAXW + 1;
    if (r == 1) return MAXW;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    cyc_t e;
    logic [5:0] o, f;
    reset = 1'b1; op = '0; funct = '0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    e = blank(3'd0); e.rdy = 1'b1;
    check("reset_held", e);
    reset = 1'b0; #1;
    check("rst_after_release", e);

    run("first_fetch_addi", 6'h08, 6'h00, 0, 0);
    run("lw_mem_wait3", 6'h23, 6'h00, 0, 3);
    run("sw_bus_err", 6'h2B, 6'h00, 0, MAXW + 1);
    run("bne", 6'h05, 6'h00, 0, 0);
    run("illegal_3f", 6'h3F, 6'h00, 0, 0);
    run("funct_jr", 6'h00, 6'b001000, 0, 0);
    run("fetch_abort", 6'h00, 6'h20, MAXW + 1, 0);
    run("fetch_at_limit", 6'h02, 6'h00, MAXW, 0);
    run("sw_at_limit", 6'h2B, 6'h00, 1, MAXW);

    // Asynchronous reset in the middle of a stalled lw memory access.
    build(6'h23, 6'h00, 0, 8);
    play("lw_pre_reset", 6'h23, 6'h00, 5);
    #1 reset = 1'b1; #1;
    e = blank(3'd0); e.rdy = mem_ready;
    check("async_reset_mid_mem", e);
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
    e.rdy = 1'b1;
    check("rst_after_async", e);
    run("jal_after_reset", 6'h03, 6'h00, 0, 0);

    for (int i = 0; i < 80; i++) begin
      int idx;
      idx = $urandom_range(0, 15);
      o   = (idx < 13) ? OPS[idx] : 6'($urandom);
      f   = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      run("random", o, f, pick_wait(), pick_wait());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
